// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble/flush counters.
// Latency: one cycle from a capture edge to valid ex_* outputs; load_use_stall is combinational.
// Backpressure: ex_flush squashes the entry, ex_hold freezes it; load_use_stall inserts one bubble.
module id_ex_pipe_reg #(
  parameter int XLEN  = 64,
  parameter int REGW  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // ID-stage instruction and decoder control bundle
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_RegWrite,
  input  logic             id_MemtoReg,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_op,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic [REGW-1:0]  id_rd,
  input  logic [3:0]       id_funct,
  // Downstream pipeline control
  input  logic             ex_hold,
  input  logic             ex_flush,
  // Registered EX-stage bundle
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_RegWrite,
  output logic             ex_MemtoReg,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [REGW-1:0]  ex_rs1,
  output logic [REGW-1:0]  ex_rs2,
  output logic [REGW-1:0]  ex_rd,
  output logic [3:0]       ex_funct,
  // Hazard and performance outputs
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // One pipeline entry; all fields move together on flush/hold/capture.
  typedef struct packed {
    logic            valid;
    logic            branch;
    logic            reg_write;
    logic            memto_reg;
    logic            mem_read;
    logic            mem_write;
    logic            alu_src;
    logic [1:0]      alu_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [3:0]      funct;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           ent_q, ent_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             capture_vld;

  // Load in EX whose destination feeds the ID instruction; x0 never creates a hazard.
  // rs2 is compared even for I-type, which can only cost a spurious stall, never a wrong result.
  assign load_use_stall = ent_q.valid & ent_q.mem_read & (ent_q.rd != '0) & id_valid &
                          ((ent_q.rd == id_rs1) | (ent_q.rd == id_rs2));

  // A stalled ID instruction enters EX as a bubble; it stays in IF/ID and captures next cycle.
  assign capture_vld = id_valid & ~load_use_stall;

  // Next-state selection: flush beats hold, hold beats capture.
  always_comb begin
    ent_d        = ent_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (ex_flush) begin
      ent_d = '0;
      if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else if (!ex_hold) begin
      ent_d.valid     = capture_vld;
      ent_d.branch    = id_branch   & capture_vld;
      ent_d.reg_write = id_RegWrite & capture_vld;
      // MemtoReg is a don't-care from the decoder unless RegWrite is set; force it clean.
      ent_d.memto_reg = id_MemtoReg & id_RegWrite & capture_vld;
      ent_d.mem_read  = id_MemRead  & capture_vld;
      ent_d.mem_write = id_MemWrite & capture_vld;
      ent_d.alu_src   = id_alu_src  & capture_vld;
      ent_d.alu_op    = id_alu_op   & {2{capture_vld}};
      ent_d.pc        = id_pc;
      ent_d.rs1_data  = id_rs1_data;
      ent_d.rs2_data  = id_rs2_data;
      ent_d.imm       = id_imm;
      ent_d.rs1       = id_rs1;
      ent_d.rs2       = id_rs2;
      ent_d.rd        = id_rd;
      ent_d.funct     = id_funct;
      if (!capture_vld && (bubble_cnt_q != CNT_MAX)) bubble_cnt_d = bubble_cnt_q + CNT_ONE;
    end
  end

  // Entry and counter state; reset discards the entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q        <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      ent_q        <= ent_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid    = ent_q.valid;
  assign ex_branch   = ent_q.branch;
  assign ex_RegWrite = ent_q.reg_write;
  assign ex_MemtoReg = ent_q.memto_reg;
  assign ex_MemRead  = ent_q.mem_read;
  assign ex_MemWrite = ent_q.mem_write;
  assign ex_alu_src  = ent_q.alu_src;
  assign ex_alu_op   = ent_q.alu_op;
  assign ex_pc       = ent_q.pc;
  assign ex_rs1_data = ent_q.rs1_data;
  assign ex_rs2_data = ent_q.rs2_data;
  assign ex_imm      = ent_q.imm;
  assign ex_rs1      = ent_q.rs1;
  assign ex_rs2      = ent_q.rs2;
  assign ex_rd       = ent_q.rd;
  assign ex_funct    = ent_q.funct;
  assign bubble_cnt  = bubble_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
